// File: rtl/spi_flash_target.sv
// Read-only SPI flash target (mode 0): READ 0x03, JEDEC ID 0x9F, and FAST READ 0x0B
// when SPI_FLASH_TARGET_FAST_READ_EN is defined. Handshake: mem_rstrb is a 1-clk read request; mem_rdata is consumed exactly 1 clk later.
module spi_flash_target #(
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [23:0] mem_addr,
    output logic        mem_rstrb,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, JEDEC, IGNORE} state_t;

    logic [1:0]  sclk_s, cs_s, mosi_s;
    logic        sclk_d;
    logic [1:0]  settle;
    logic        armed;
    state_t      state;
    logic [4:0]  bit_cnt;
    logic [2:0]  out_cnt;
    logic [22:0] shift_in;
    logic [6:0]  shift_out;
    logic [7:0]  next_byte;
    logic [1:0]  jedec_idx;
    logic        rd_pending;
    logic        miso_q, oe_q, rstrb_q;
    logic [23:0] addr_q;
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
    logic        fast;
`endif

    logic sck_rise, sck_fall, cs_high, mosi_bit;
    logic [7:0] jedec_byte, load_byte;

    assign sck_rise = sclk_s[1] & ~sclk_d;
    assign sck_fall = ~sclk_s[1] & sclk_d;
    assign cs_high  = cs_s[1];
    assign mosi_bit = mosi_s[1];

    always_comb begin
        jedec_byte = 8'h00;
        case (jedec_idx)
            2'd0:    jedec_byte = JEDEC_ID[23:16];
            2'd1:    jedec_byte = JEDEC_ID[15:8];
            2'd2:    jedec_byte = JEDEC_ID[7:0];
            default: jedec_byte = 8'h00;
        endcase
        load_byte = (state == DATA) ? next_byte : jedec_byte;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s <= 2'b00;
            cs_s   <= 2'b11;
            mosi_s <= 2'b00;
            sclk_d <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], spi_clk};
            cs_s   <= {cs_s[0], spi_cs_n};
            mosi_s <= {mosi_s[0], spi_mosi};
            sclk_d <= sclk_s[1];
        end
    end

    // A transfer may only start after CS_N has been seen high once the
    // synchronizer has flushed its reset value; a CS_N held low across reset is not a new select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            armed  <= armed | (settle[1] & cs_s[1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            out_cnt    <= '0;
            shift_in   <= '0;
            shift_out  <= '0;
            next_byte  <= '0;
            jedec_idx  <= '0;
            rd_pending <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            rstrb_q    <= 1'b0;
            addr_q     <= '0;
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
            fast       <= 1'b0;
`endif
        end else begin
            rstrb_q    <= 1'b0;
            rd_pending <= rstrb_q;
            if (cs_high) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                out_cnt    <= '0;
                jedec_idx  <= '0;
                rd_pending <= 1'b0;
                miso_q     <= 1'b0;
                oe_q       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        if (armed) state <= CMD;
                    end
                    CMD: if (sck_rise) begin
                        shift_in <= {shift_in[21:0], mosi_bit};
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            out_cnt <= '0;
                            case ({shift_in[6:0], mosi_bit})
                                8'h03: begin
                                    state <= ADDR;
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
                                    fast  <= 1'b0;
`endif
                                end
                                8'h9F: begin
                                    state     <= JEDEC;
                                    oe_q      <= 1'b1;
                                    jedec_idx <= '0;
                                end
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
                                8'h0B: begin
                                    state <= ADDR;
                                    fast  <= 1'b1;
                                end
`endif
                                default: state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR, DUMMY: begin
                        if (sck_rise) begin
                            shift_in <= {shift_in[21:0], mosi_bit};
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (state == ADDR && bit_cnt == 5'd23) begin
                                addr_q  <= {shift_in[22:0], mosi_bit};
                                bit_cnt <= '0;
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
                                if (fast) state <= DUMMY;
                                else rstrb_q <= 1'b1;
`else
                                rstrb_q <= 1'b1;
`endif
                            end
                            if (state == DUMMY && bit_cnt == 5'd7) begin
                                rstrb_q <= 1'b1;
                                bit_cnt <= '0;
                            end
                        end
                        // First byte has arrived: park it until the next SCK fall shifts it out.
                        if (rd_pending) begin
                            next_byte <= mem_rdata;
                            state     <= DATA;
                            oe_q      <= 1'b1;
                            out_cnt   <= '0;
                        end
                    end
                    DATA, JEDEC: begin
                        if (state == DATA && rd_pending) next_byte <= mem_rdata;
                        if (sck_fall) begin
                            out_cnt <= out_cnt + 3'd1;
                            if (out_cnt == 3'd0) begin
                                miso_q    <= load_byte[7];
                                shift_out <= load_byte[6:0];
                                if (state == DATA) begin
                                    addr_q  <= addr_q + 24'd1;
                                    rstrb_q <= 1'b1;
                                end else if (jedec_idx != 2'd3) begin
                                    jedec_idx <= jedec_idx + 2'd1;
                                end
                            end else begin
                                miso_q    <= shift_out[6];
                                shift_out <= {shift_out[5:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_addr    = addr_q;
    assign mem_rstrb   = rstrb_q;
    assign busy        = ~cs_s[1];

endmodule

// File: tb/tb_spi_flash_target.sv
// Directed bench for spi_flash_target: JEDEC ID, reads, address wrap, unknown
// command, aborted byte, mid-stream reset and the optional fast read.
module tb_spi_flash_target;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, mem_rstrb, busy;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;
    logic        oe_seen = 1'b0;
    logic [23:0] strobe_q[$];
    logic [7:0]  exp_q[$];

    spi_flash_target dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            24'hFFFFFF: return 8'hA7;
            24'h000000: return 8'h5C;
            default:    return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    // Local store: data valid exactly one clk after the strobe.
    always @(posedge clk) begin
        if (mem_rstrb) begin
            mem_rdata <= mem_byte(mem_addr);
            strobe_q.push_back(mem_addr);
        end
    end

    always @(negedge clk) if (spi_miso_oe) oe_seen = 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required finish before 500000 ns");
        $fatal(1, "watchdog");
    end

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            #80;
            rx[7-i] = spi_miso;
            spi_clk = 1'b1;
            #80;
            spi_clk = 1'b0;
        end
    endtask

    task automatic begin_txn();
        spi_cs_n = 1'b0;
        #200;
    endtask

    task automatic end_txn();
        #100;
        spi_cs_n = 1'b1;
        #300;
    endtask

    task automatic send_cmd4(input logic [7:0] c, input logic [23:0] a);
        logic [7:0] rx;
        spi_bits(c, 8, rx);
        spi_bits(a[23:16], 8, rx);
        spi_bits(a[15:8], 8, rx);
        spi_bits(a[7:0], 8, rx);
    endtask

    task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #30;
        checks += 5;
        if (spi_miso !== 1'b0)    begin errors++; $display("FAIL reset_miso: got %b, expected 0", spi_miso); end
        if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b, expected 0", spi_miso_oe); end
        if (mem_rstrb !== 1'b0)   begin errors++; $display("FAIL reset_rstrb: got %b, expected 0", mem_rstrb); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (mem_addr !== 24'h0)   begin errors++; $display("FAIL reset_addr: got %06h, expected 000000", mem_addr); end
        reset = 1'b0;
        #100;
    endtask

    task automatic test_jedec();
        logic [7:0] rx;
        exp_q = '{8'hEF, 8'h40, 8'h16, 8'h00};
        strobe_q.delete();
        begin_txn();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL jedec_busy: got %b, expected 1", busy); end
        spi_bits(8'h9F, 8, rx);
        for (int i = 0; i < 4; i++) begin
            spi_bits(8'h00, 8, rx);
            check_byte("jedec_byte", rx, exp_q.pop_front());
        end
        end_txn();
        checks++;
        if (strobe_q.size() != 0) begin errors++; $display("FAIL jedec_rstrb: got %0d strobes, expected 0", strobe_q.size()); end
    endtask

    task automatic test_read();
        logic [7:0] rx;
        logic [23:0] a;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        strobe_q.delete();
        begin_txn();
        send_cmd4(8'h03, 24'h000100);
        for (int i = 0; i < 4; i++) begin
            spi_bits(8'h00, 8, rx);
            check_byte("read_byte", rx, exp_q.pop_front());
        end
        end_txn();
        for (int i = 0; i < 4; i++) begin
            a = (strobe_q.size() > 0) ? strobe_q.pop_front() : 24'hXXXXXX;
            checks++;
            if (a !== 24'h000100 + 24'(i)) begin
                errors++;
                $display("FAIL read_addr: got %06h, expected %06h", a, 24'h000100 + 24'(i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] rx;
        logic [23:0] a;
        strobe_q.delete();
        begin_txn();
        send_cmd4(8'h03, 24'hFFFFFF);
        spi_bits(8'h00, 8, rx);
        check_byte("wrap_byte0", rx, 8'hA7);
        spi_bits(8'h00, 8, rx);
        check_byte("wrap_byte1", rx, 8'h5C);
        end_txn();
        a = (strobe_q.size() > 1) ? strobe_q[1] : 24'hXXXXXX;
        checks++;
        if (a !== 24'h000000) begin errors++; $display("FAIL wrap_addr: got %06h, expected 000000", a); end
    endtask

    task automatic test_ignore();
        logic [7:0] rx;
        oe_seen = 1'b0;
        strobe_q.delete();
        begin_txn();
        spi_bits(8'hA5, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        end_txn();
        checks++;
        if (oe_seen !== 1'b0 || strobe_q.size() != 0) begin
            errors++;
            $display("FAIL ignore_quiet: got oe_seen %b strobes %0d, expected 0 and 0", oe_seen, strobe_q.size());
        end
        begin_txn();
        spi_bits(8'h9F, 8, rx);
        spi_bits(8'h00, 8, rx);
        check_byte("ignore_then_jedec", rx, 8'hEF);
        end_txn();
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        begin_txn();
        send_cmd4(8'h03, 24'h000100);
        spi_bits(8'h00, 8, rx);
        check_byte("abort_first", rx, 8'h11);
        spi_bits(8'h00, 4, rx);
        end_txn();
        checks++;
        if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b, expected 0", spi_miso_oe); end
        begin_txn();
        spi_bits(8'h9F, 8, rx);
        spi_bits(8'h00, 8, rx);
        check_byte("abort_jedec0", rx, 8'hEF);
        spi_bits(8'h00, 8, rx);
        check_byte("abort_jedec1", rx, 8'h40);
        end_txn();
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        begin_txn();
        send_cmd4(8'h03, 24'h000100);
        spi_bits(8'h00, 8, rx);
        check_byte("mid_first", rx, 8'h11);
        spi_bits(8'h00, 3, rx);
        reset = 1'b1;
        #1;
        checks++;
        if ({spi_miso, spi_miso_oe, mem_rstrb, busy} !== 4'b0000 || mem_addr !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got miso %b oe %b rstrb %b busy %b addr %06h, expected all 0",
                     spi_miso, spi_miso_oe, mem_rstrb, busy, mem_addr);
        end
        #29;
        reset = 1'b0;
        #50;
        oe_seen = 1'b0;
        strobe_q.delete();
        spi_bits(8'h9F, 8, rx);
        spi_bits(8'h00, 8, rx);
        checks++;
        if (oe_seen !== 1'b0 || strobe_q.size() != 0) begin
            errors++;
            $display("FAIL mid_no_restart: got oe_seen %b strobes %0d, expected 0 and 0", oe_seen, strobe_q.size());
        end
        end_txn();
        begin_txn();
        spi_bits(8'h9F, 8, rx);
        spi_bits(8'h00, 8, rx);
        check_byte("mid_then_jedec", rx, 8'hEF);
        end_txn();
    endtask

    task automatic test_fast_read();
        logic [7:0] rx;
        oe_seen = 1'b0;
        begin_txn();
        send_cmd4(8'h0B, 24'h000100);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
        check_byte("fast_byte", rx, 8'h11);
`else
        checks++;
        if (oe_seen !== 1'b0) begin errors++; $display("FAIL fast_disabled_oe: got %b, expected 0", oe_seen); end
`endif
        end_txn();
    endtask

    initial begin
        test_reset();
        test_jedec();
        test_read();
        test_wrap();
        test_ignore();
        test_abort();
        test_reset_mid();
        test_fast_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
